dmem_lsu: RTL and testbench

DMEM_LSU -- requirements
Module: dmem_lsu

---
 rtl/dmem_lsu.sv | 193 +++++++++++++++++++
 tb/tb_dmem_lsu.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_lsu.sv
// ============================================================================
//  Module      : dmem_lsu
//  Description : Data-memory load/store unit. Accepts one core request at a
//                time, performs aligned byte/half/word loads with sign or zero
//                extension, word stores directly, and byte/half stores as a
//                read-modify-write against a memory that zeroes unmasked
//                bytes. Every output is registered.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module dmem_lsu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic        dmwr_req,
    output logic [3:0]  dmwr_mask,
    output logic [31:0] dmdata_in,
    output logic [31:0] dmaddr,
    input  logic [31:0] dmdata_out1
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_CAP  = 2'd2,
        S_WR   = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    // Request fields held for the duration of the operation
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [1:0]  r_lane;
    logic [15:0] r_wdata;

    // Next values of the registered outputs
    logic        w_req_ready;
    logic        w_resp_valid;
    logic        w_resp_err;
    logic [31:0] w_resp_rdata;
    logic        w_dmwr_req;
    logic [3:0]  w_dmwr_mask;
    logic [31:0] w_dmdata_in;
    logic [31:0] w_dmaddr;

    logic        w_accept;
    logic        w_req_err;
    logic [31:0] w_shift;
    logic [31:0] w_load_data;
    logic [31:0] w_merge;

    assign w_accept  = req_valid && req_ready;
    assign w_req_err = (req_size == 2'd3)
                     | ((req_size == 2'd1) & req_addr[0])
                     | ((req_size == 2'd2) & (req_addr[1:0] != 2'b00));

    // Select the addressed lane of the read word and extend it to 32 bits
    always_comb begin
        w_shift = dmdata_out1 >> {r_lane, 3'b000};
        case (r_size)
            2'd0:    w_load_data = {{24{~r_unsigned & w_shift[7]}},  w_shift[7:0]};
            2'd1:    w_load_data = {{16{~r_unsigned & w_shift[15]}}, w_shift[15:0]};
            default: w_load_data = w_shift;
        endcase
    end

    // Overlay the store bytes onto the word just read for read-modify-write
    always_comb begin
        w_merge = dmdata_out1;
        if (r_size == 2'd0) begin
            w_merge[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
        end else begin
            w_merge[{r_lane[1], 4'b0000} +: 16] = r_wdata[15:0];
        end
    end

    // Next-state and next-output decode; defaults first so nothing latches
    always_comb begin
        w_state_nxt  = r_state;
        w_resp_valid = 1'b0;
        w_resp_err   = 1'b0;
        w_resp_rdata = 32'd0;
        w_dmwr_req   = 1'b0;
        w_dmwr_mask  = 4'b0000;
        w_dmdata_in  = dmdata_in;
        w_dmaddr     = dmaddr;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_req_err) begin
                        // Rejected on the accept edge; memory is never touched
                        w_resp_valid = 1'b1;
                        w_resp_err   = 1'b1;
                    end else begin
                        w_dmaddr = {2'b00, req_addr[31:2]};
                        if (!req_we) begin
                            w_state_nxt = S_RD;
                        end else if (req_size == 2'd2) begin
                            w_state_nxt = S_WR;
                            w_dmwr_req  = 1'b1;
                            w_dmwr_mask = 4'b1111;
                            w_dmdata_in = req_wdata;
                        end else begin
                            // Sub-word store must fetch the word first
                            w_state_nxt = S_RD;
                        end
                    end
                end
            end
            S_RD: begin
                w_state_nxt = S_CAP;
            end
            S_CAP: begin
                if (!r_we) begin
                    w_state_nxt  = S_IDLE;
                    w_resp_valid = 1'b1;
                    w_resp_rdata = w_load_data;
                end else begin
                    w_state_nxt = S_WR;
                    w_dmwr_req  = 1'b1;
                    w_dmwr_mask = 4'b1111;
                    w_dmdata_in = w_merge;
                end
            end
            S_WR: begin
                w_state_nxt  = S_IDLE;
                w_resp_valid = 1'b1;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        w_req_ready = (w_state_nxt == S_IDLE);
    end

    // State register and registered outputs; reset aborts any operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'd0;
            dmwr_req   <= 1'b0;
            dmwr_mask  <= 4'b0000;
            dmdata_in  <= 32'd0;
            dmaddr     <= 32'd0;
        end else begin
            r_state    <= w_state_nxt;
            req_ready  <= w_req_ready;
            resp_valid <= w_resp_valid;
            resp_err   <= w_resp_err;
            resp_rdata <= w_resp_rdata;
            dmwr_req   <= w_dmwr_req;
            dmwr_mask  <= w_dmwr_mask;
            dmdata_in  <= w_dmdata_in;
            dmaddr     <= w_dmaddr;
        end
    end

    // Capture the request fields on every accepted request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we       <= 1'b0;
            r_size     <= 2'd0;
            r_unsigned <= 1'b0;
            r_lane     <= 2'd0;
            r_wdata    <= 16'd0;
        end else if (w_accept) begin
            r_we       <= req_we;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_lane     <= req_addr[1:0];
            r_wdata    <= req_wdata[15:0];
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dmem_lsu.sv
// ============================================================================
//  Module      : tb_dmem_lsu
//  Description : Self-checking bench for dmem_lsu with a registered-read data
//                memory and a request-level reference model of the expected
//                responses, write pulses and memory contents.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dmem_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic        dmwr_req;
    logic [3:0]  dmwr_mask;
    logic [31:0] dmdata_in;
    logic [31:0] dmaddr;
    logic [31:0] dmdata_out1;

    int n_checks = 0;
    int n_errors = 0;
    int edge_n   = 0;
    int since    = 0;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        int          due;
    } req_t;

    req_t        q[$];
    logic [31:0] ref_mem [0:255];
    logic [31:0] mem     [0:255];
    logic [31:0] rdq;
    logic        pre_we = 1'b0;
    logic [7:0]  pre_idx = 8'd0;
    logic [31:0] pre_data = 32'd0;

    dmem_lsu dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_err     (resp_err),
        .resp_rdata   (resp_rdata),
        .dmwr_req     (dmwr_req),
        .dmwr_mask    (dmwr_mask),
        .dmdata_in    (dmdata_in),
        .dmaddr       (dmaddr),
        .dmdata_out1  (dmdata_out1)
    );

    always #5 clk = ~clk;

    // Data memory: registered read, write zeroes bytes outside the mask
    always @(posedge clk) begin
        if (pre_we)
            mem[pre_idx] <= pre_data;
        else if (dmwr_req)
            mem[dmaddr[7:0]] <= dmdata_in & {{8{dmwr_mask[3]}}, {8{dmwr_mask[2]}},
                                             {8{dmwr_mask[1]}}, {8{dmwr_mask[0]}}};
        else
            rdq <= mem[dmaddr[7:0]];
    end
    assign dmdata_out1 = rdq;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic is_err(logic [1:0] size, logic [31:0] a);
        return (size == 2'd3) || (size == 2'd1 && a[0]) || (size == 2'd2 && a[1:0] != 2'b00);
    endfunction

    // Edges from accept (accept edge counted as the first) to the response
    function automatic int latency(logic we, logic [1:0] size, logic [31:0] a);
        if (is_err(size, a)) return 1;
        if (!we)             return 3;
        if (size == 2'd2)    return 2;
        return 4;
    endfunction

    function automatic logic [31:0] load_val(logic [31:0] w, logic [1:0] size, logic uns, logic [1:0] lane);
        logic [31:0] s;
        s = w >> (8 * lane);
        if (size == 2'd0) begin
            s = s & 32'h0000_00FF;
            if (!uns && s[7]) s = s | 32'hFFFF_FF00;
        end else if (size == 2'd1) begin
            s = s & 32'h0000_FFFF;
            if (!uns && s[15]) s = s | 32'hFFFF_0000;
        end else begin
            s = w;
        end
        return s;
    endfunction

    function automatic logic [31:0] merge(logic [31:0] w, logic [1:0] size, logic [1:0] lane, logic [31:0] wd);
        logic [31:0] m;
        int          sh;
        if (size == 2'd2) return wd;
        m  = (size == 2'd0) ? 32'h0000_00FF : 32'h0000_FFFF;
        sh = 8 * lane;
        return (w & ~(m << sh)) | ((wd & m) << sh);
    endfunction

    // Reference model and per-cycle compare
    initial begin
        req_t        r;
        logic        exp_v;
        logic        exp_w;
        logic [7:0]  idx;
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'd0;
        forever begin
            @(posedge clk);
            edge_n++;
            since = rst_n ? since + 1 : 0;
            if (pre_we) ref_mem[pre_idx] = pre_data;
            if (rst_n && req_valid && req_ready) begin
                r.we    = req_we;
                r.size  = req_size;
                r.uns   = req_unsigned;
                r.addr  = req_addr;
                r.wdata = req_wdata;
                r.err   = is_err(req_size, req_addr);
                r.due   = edge_n + latency(req_we, req_size, req_addr) - 1;
                q.push_back(r);
            end
            @(negedge clk);
            if (!rst_n) begin
                q.delete();
            end else begin
                exp_v = (q.size() > 0) && (q[0].due == edge_n);
                exp_w = (q.size() > 0) && !q[0].err && q[0].we && (q[0].due == edge_n + 1);
                chk("req_ready", {31'd0, req_ready}, {31'd0, (since >= 1) && (q.size() == 0 || exp_v)});
                chk("dmwr_req", {31'd0, dmwr_req}, {31'd0, exp_w});
                if (exp_w) begin
                    idx = q[0].addr[9:2];
                    chk("dmwr_mask", {28'd0, dmwr_mask}, 32'h0000_000F);
                    chk("dmaddr", dmaddr, {2'b00, q[0].addr[31:2]});
                    chk("dmdata_in", dmdata_in,
                        merge(ref_mem[idx], q[0].size, q[0].addr[1:0], q[0].wdata));
                end else begin
                    chk("dmwr_mask_idle", {28'd0, dmwr_mask}, 32'd0);
                end
                chk("resp_valid", {31'd0, resp_valid}, {31'd0, exp_v});
                if (exp_v) begin
                    idx = q[0].addr[9:2];
                    chk("resp_err", {31'd0, resp_err}, {31'd0, q[0].err});
                    if (q[0].err) begin
                        chk("resp_rdata_err", resp_rdata, 32'd0);
                    end else if (q[0].we) begin
                        chk("resp_rdata_st", resp_rdata, 32'd0);
                        ref_mem[idx] = merge(ref_mem[idx], q[0].size, q[0].addr[1:0], q[0].wdata);
                    end else begin
                        chk("resp_rdata_ld", resp_rdata,
                            load_val(ref_mem[idx], q[0].size, q[0].uns, q[0].addr[1:0]));
                    end
                    void'(q.pop_front());
                end
            end
        end
    end

    task automatic preload(input logic [7:0] i, input logic [31:0] d);
        @(negedge clk);
        pre_we   = 1'b1;
        pre_idx  = i;
        pre_data = d;
        @(negedge clk);
        pre_we   = 1'b0;
    endtask

    task automatic wait_ready(input string nm);
        int n;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk({nm, ".ready_timeout"}, {31'd0, req_ready}, 32'd1);
    endtask

    task automatic drive(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd);
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = a;
        req_wdata    = wd;
        req_valid    = 1'b1;
    endtask

    // Issue one request and check its response and latency against literals
    task automatic do_req(input string nm, input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic exp_err, input logic [31:0] exp_rd, input int exp_n);
        int n;
        @(negedge clk);
        wait_ready(nm);
        drive(we, sz, uns, a, wd);
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!resp_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk({nm, ".valid"},   {31'd0, resp_valid}, 32'd1);
        chk({nm, ".latency"}, n,                   exp_n);
        chk({nm, ".err"},     {31'd0, resp_err},   {31'd0, exp_err});
        chk({nm, ".rdata"},   resp_rdata,          exp_rd);
    endtask

    initial begin
        int n;
        #12;
        chk("rst.req_ready",  {31'd0, req_ready},  32'd0);
        chk("rst.resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst.resp_err",   {31'd0, resp_err},   32'd0);
        chk("rst.resp_rdata", resp_rdata,          32'd0);
        chk("rst.dmwr_req",   {31'd0, dmwr_req},   32'd0);
        chk("rst.dmwr_mask",  {28'd0, dmwr_mask},  32'd0);
        chk("rst.dmaddr",     dmaddr,              32'd0);
        chk("rst.dmdata_in",  dmdata_in,           32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1 chk("rst.ready_after", {31'd0, req_ready}, 32'd1);

        // Word store then word load of the same address
        do_req("sw10", 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'd0, 1);
        do_req("lw10", 1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 1'b0, 32'hDEAD_BEEF, 2);

        // Byte store into a preloaded word via read-modify-write
        preload(8'd8, 32'h1122_3344);
        do_req("sb21", 1'b1, 2'd0, 1'b0, 32'h21, 32'h0000_00AA, 1'b0, 32'd0, 3);
        do_req("lw20", 1'b0, 2'd2, 1'b0, 32'h20, 32'd0, 1'b0, 32'h1122_AA44, 2);

        // Sub-word loads with sign and zero extension
        preload(8'd12, 32'h80FF_7F01);
        do_req("lb32",  1'b0, 2'd0, 1'b0, 32'h32, 32'd0, 1'b0, 32'hFFFF_FFFF, 2);
        do_req("lbu33", 1'b0, 2'd0, 1'b1, 32'h33, 32'd0, 1'b0, 32'h0000_0080, 2);
        do_req("lh30",  1'b0, 2'd1, 1'b0, 32'h30, 32'd0, 1'b0, 32'h0000_7F01, 2);
        do_req("lhu32", 1'b0, 2'd1, 1'b1, 32'h32, 32'd0, 1'b0, 32'h0000_80FF, 2);

        // Upper-half store then word read-back
        do_req("sh32", 1'b1, 2'd1, 1'b0, 32'h32, 32'h5555_BEEF, 1'b0, 32'd0, 3);
        do_req("lw30", 1'b0, 2'd2, 1'b0, 32'h30, 32'd0, 1'b0, 32'hBEEF_7F01, 2);

        // Misaligned and illegal-size requests
        do_req("lh31",  1'b0, 2'd1, 1'b0, 32'h31, 32'd0,        1'b1, 32'd0, 0);
        do_req("sw42",  1'b1, 2'd2, 1'b0, 32'h42, 32'h1234_5678, 1'b1, 32'd0, 0);
        do_req("size3", 1'b0, 2'd3, 1'b0, 32'h00, 32'd0,        1'b1, 32'd0, 0);

        // Back-to-back: second request held valid through the first response
        @(negedge clk);
        wait_ready("b2b");
        drive(1'b1, 2'd2, 1'b0, 32'h50, 32'h1357_2468);
        @(posedge clk);
        #1 drive(1'b0, 2'd2, 1'b0, 32'h50, 32'd0);
        n = 0;
        @(negedge clk);
        while (!resp_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("b2b.a_valid",   {31'd0, resp_valid}, 32'd1);
        chk("b2b.a_latency", n,                   1);
        chk("b2b.ready",     {31'd0, req_ready},  32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!resp_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("b2b.b_latency", n,          2);
        chk("b2b.b_rdata",   resp_rdata, 32'h1357_2468);

        // Reset pulsed while a half store sits in the capture state
        preload(8'd24, 32'hCAFE_F00D);
        @(negedge clk);
        wait_ready("abort");
        drive(1'b1, 2'd1, 1'b0, 32'h62, 32'h0000_1234);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("abort.dmwr_req",   {31'd0, dmwr_req},   32'd0);
        chk("abort.resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("abort.req_ready",  {31'd0, req_ready},  32'd0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1 chk("abort.ready_after", {31'd0, req_ready}, 32'd1);
        do_req("lw60", 1'b0, 2'd2, 1'b0, 32'h60, 32'd0, 1'b0, 32'hCAFE_F00D, 2);

        // Memory contents must match the reference image
        repeat (3) @(negedge clk);
        chk("mem[4]",  mem[4],  ref_mem[4]);
        chk("mem[8]",  mem[8],  ref_mem[8]);
        chk("mem[12]", mem[12], ref_mem[12]);
        chk("mem[20]", mem[20], ref_mem[20]);
        chk("mem[24]", mem[24], ref_mem[24]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Hard time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
